// File: rtl/ex_pkg.sv
// Shared types for the execute stage: ALU controls, forward selects, MDU states and M-ext funct3 codes.
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage, bundled with modports.
interface ex_stage_mdu_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned RD_W   = 5
);
    logic              valid_i, flush_i, stall_i;
    logic [XLEN-1:0]   pc_i, imm_i, rd1_i, rd2_i, res_m_i, res_w_i;
    logic [1:0]        fwd_a_i, fwd_b_i, alu_op_i;
    logic              alu_src_i, funct7_5_i, md_i;
    logic [2:0]        funct3_i;
    logic [RD_W-1:0]   rd_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              busy_o, valid_o, eq_o;
    logic [XLEN-1:0]   alu_out_o, pc_imm_o, wdata_o;
    logic [RD_W-1:0]   rd_o;
    logic [CTRL_W-1:0] ctrl_o;

    modport slave (
        input  valid_i, flush_i, stall_i, pc_i, imm_i, rd1_i, rd2_i, res_m_i, res_w_i,
               fwd_a_i, fwd_b_i, alu_op_i, alu_src_i, funct7_5_i, md_i, funct3_i, rd_i, ctrl_i,
        output busy_o, valid_o, eq_o, alu_out_o, pc_imm_o, wdata_o, rd_o, ctrl_o
    );

    modport master (
        output valid_i, flush_i, stall_i, pc_i, imm_i, rd1_i, rd2_i, res_m_i, res_w_i,
               fwd_a_i, fwd_b_i, alu_op_i, alu_src_i, funct7_5_i, md_i, funct3_i, rd_i, ctrl_i,
        input  busy_o, valid_o, eq_o, alu_out_o, pc_imm_o, wdata_o, rd_o, ctrl_o
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M core: shift-add multiply / restoring divide on magnitudes, one bit per cycle,
// signs re-applied on the result. A tag (rd + ctrl) travels with the operation.
module mdu_iter
    import ex_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             ack_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    output mdu_state_e       state_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);
    localparam int unsigned CW = $clog2(XLEN);

    mdu_state_e         r_state;
    md_op_e             r_op;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;
    logic [XLEN-1:0]    r_opnd;
    logic [2*XLEN-1:0]  r_p;
    logic [TAG_W-1:0]   r_tag;

    md_op_e             w_op;
    logic               w_a_sgn, w_b_sgn, w_is_div, w_divz, w_neg;
    logic [XLEN-1:0]    w_a_mag, w_b_mag, w_q, w_r;
    logic [XLEN:0]      w_sum, w_rem, w_trial;
    logic [2*XLEN:0]    w_sh;
    logic [2*XLEN-1:0]  w_mul_nxt, w_div_nxt, w_prod;

    assign w_op     = md_op_e'(funct3_i);
    assign w_is_div = funct3_i[2];
    assign w_divz   = (b_i == '0);
    assign w_a_sgn  = (w_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & a_i[XLEN-1];
    assign w_b_sgn  = (w_op inside {MD_MULH, MD_DIV, MD_REM}) & b_i[XLEN-1];
    assign w_a_mag  = w_a_sgn ? -a_i : a_i;
    assign w_b_mag  = w_b_sgn ? -b_i : b_i;

    // Divide-by-zero naturally yields all-ones quotient and |a| remainder; only the quotient sign must be suppressed.
    always_comb begin
        if (w_op == MD_REM)      w_neg = w_a_sgn;
        else if (w_op == MD_DIV) w_neg = (w_a_sgn ^ w_b_sgn) & ~w_divz;
        else                     w_neg = w_a_sgn ^ w_b_sgn;
    end

    assign w_sum     = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_sum, r_p[XLEN-1:1]};
    assign w_sh      = {r_p, 1'b0};
    assign w_rem     = w_sh[2*XLEN:XLEN];
    assign w_trial   = w_rem - {1'b0, r_opnd};
    assign w_div_nxt = w_trial[XLEN] ? w_sh[2*XLEN-1:0] : {w_trial[XLEN-1:0], w_sh[XLEN-1:1], 1'b1};

    assign w_prod = r_neg ? -r_p : r_p;
    assign w_q    = r_neg ? -r_p[XLEN-1:0] : r_p[XLEN-1:0];
    assign w_r    = r_neg ? -r_p[2*XLEN-1:XLEN] : r_p[2*XLEN-1:XLEN];

    always_comb begin
        case (r_op)
            MD_MUL:                      result_o = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             result_o = w_q;
            default:                     result_o = w_r;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || abort_i) begin
            r_state <= IDLE;
            r_op    <= MD_MUL;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_opnd  <= '0;
            r_p     <= '0;
            r_tag   <= '0;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    r_state <= BUSY;
                    r_op    <= w_op;
                    r_cnt   <= CW'(XLEN-1);
                    r_neg   <= w_neg;
                    r_opnd  <= w_is_div ? w_b_mag : w_a_mag;
                    r_p     <= {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                    r_tag   <= tag_i;
                end
                BUSY: begin
                    r_p   <= r_op[2] ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= DONE;
                end
                DONE: if (ack_i) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign state_o = r_state;
    assign tag_o   = r_tag;
endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: forwarding, ALU, EX/MEM register and, with EX_MDU_EN defined, the iterative
// multiply/divide unit. Without EX_MDU_EN, md_i is ignored and busy_o is tied low.
module ex_stage_mdu
    import ex_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned RD_W   = 5
) (
    input logic             clk_i,
    input logic             rst_i,
    ex_stage_mdu_if.slave   bus
);
    localparam int unsigned SW = $clog2(XLEN);

    logic [XLEN-1:0]   w_src_a, w_src_b, w_op2, w_alu_res;
    logic [SW-1:0]     w_shamt;
    alu_ctrl_e         w_alu_ctrl;
    logic              w_md_done, w_md_hold;
    logic [XLEN-1:0]   w_md_res;
    logic [RD_W+CTRL_W-1:0] w_md_tag;

    logic              r_valid, r_eq;
    logic [XLEN-1:0]   r_alu_out, r_pc_imm, r_wdata;
    logic [RD_W-1:0]   r_rd;
    logic [CTRL_W-1:0] r_ctrl;

    always_comb begin
        case (bus.fwd_a_i)
            FWD_W:   w_src_a = bus.res_w_i;
            FWD_M:   w_src_a = bus.res_m_i;
            default: w_src_a = bus.rd1_i;
        endcase
        case (bus.fwd_b_i)
            FWD_W:   w_src_b = bus.res_w_i;
            FWD_M:   w_src_b = bus.res_m_i;
            default: w_src_b = bus.rd2_i;
        endcase
    end

    assign w_op2   = bus.alu_src_i ? bus.imm_i : w_src_b;
    assign w_shamt = w_op2[SW-1:0];

    // Bit 30 selects SUB only for register-register ops; for ADDI it is an immediate bit.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        if (bus.alu_op_i == 2'b01) begin
            w_alu_ctrl = ALU_SUB;
        end else if (bus.alu_op_i == 2'b10) begin
            case (bus.funct3_i)
                3'b000: w_alu_ctrl = (bus.funct7_5_i && !bus.alu_src_i) ? ALU_SUB : ALU_ADD;
                3'b001: w_alu_ctrl = ALU_SLL;
                3'b010: w_alu_ctrl = ALU_SLT;
                3'b011: w_alu_ctrl = ALU_SLTU;
                3'b100: w_alu_ctrl = ALU_XOR;
                3'b101: w_alu_ctrl = bus.funct7_5_i ? ALU_SRA : ALU_SRL;
                3'b110: w_alu_ctrl = ALU_OR;
                default: w_alu_ctrl = ALU_AND;
            endcase
        end
    end

    always_comb begin
        case (w_alu_ctrl)
            ALU_SUB:  w_alu_res = w_src_a - w_op2;
            ALU_AND:  w_alu_res = w_src_a & w_op2;
            ALU_OR:   w_alu_res = w_src_a | w_op2;
            ALU_XOR:  w_alu_res = w_src_a ^ w_op2;
            ALU_SLL:  w_alu_res = w_src_a << w_shamt;
            ALU_SRL:  w_alu_res = w_src_a >> w_shamt;
            ALU_SRA:  w_alu_res = $signed(w_src_a) >>> w_shamt;
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_src_a) < $signed(w_op2)};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_src_a < w_op2};
            default:  w_alu_res = w_src_a + w_op2;
        endcase
    end

`ifdef EX_MDU_EN
    mdu_state_e w_md_state;
    logic       w_md_start;

    assign w_md_start = bus.valid_i & bus.md_i & ~bus.flush_i;

    mdu_iter #(
        .XLEN  (XLEN),
        .TAG_W (RD_W + CTRL_W)
    ) u_mdu (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (w_md_start),
        .abort_i  (bus.flush_i),
        .ack_i    (~bus.stall_i),
        .funct3_i (bus.funct3_i),
        .a_i      (w_src_a),
        .b_i      (w_src_b),
        .tag_i    ({bus.rd_i, bus.ctrl_i}),
        .state_o  (w_md_state),
        .result_o (w_md_res),
        .tag_o    (w_md_tag)
    );

    assign w_md_done  = (w_md_state == DONE);
    assign w_md_hold  = w_md_start | (w_md_state == BUSY);
    assign bus.busy_o = ((w_md_state == IDLE) && bus.valid_i && bus.md_i) ||
                        (w_md_state == BUSY) || ((w_md_state == DONE) && bus.stall_i);
`else
    logic w_unused_md;

    assign w_unused_md = bus.md_i;
    assign w_md_done   = 1'b0;
    assign w_md_hold   = 1'b0;
    assign w_md_res    = '0;
    assign w_md_tag    = '0;
    assign bus.busy_o  = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.flush_i) begin
            r_valid   <= 1'b0;
            r_eq      <= 1'b0;
            r_alu_out <= '0;
            r_pc_imm  <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_ctrl    <= '0;
        end else if (!bus.stall_i) begin
            if (w_md_done) begin
                r_valid         <= 1'b1;
                r_eq            <= 1'b0;
                r_alu_out       <= w_md_res;
                r_pc_imm        <= '0;
                r_wdata         <= '0;
                {r_rd, r_ctrl}  <= w_md_tag;
            end else if (w_md_hold) begin
                r_valid   <= 1'b0;
                r_eq      <= 1'b0;
                r_alu_out <= '0;
                r_pc_imm  <= '0;
                r_wdata   <= '0;
                r_rd      <= '0;
                r_ctrl    <= '0;
            end else begin
                r_valid   <= bus.valid_i;
                r_eq      <= (w_src_a == w_op2);
                r_alu_out <= w_alu_res;
                r_pc_imm  <= bus.pc_i + bus.imm_i;
                r_wdata   <= w_src_b;
                r_rd      <= bus.rd_i;
                r_ctrl    <= bus.valid_i ? bus.ctrl_i : '0;
            end
        end
    end

    assign bus.valid_o   = r_valid;
    assign bus.eq_o      = r_eq;
    assign bus.alu_out_o = r_alu_out;
    assign bus.pc_imm_o  = r_pc_imm;
    assign bus.wdata_o   = r_wdata;
    assign bus.rd_o      = r_rd;
    assign bus.ctrl_o    = r_ctrl;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed + randomized bench for ex_stage_mdu; MDU scenarios run when EX_MDU_EN is defined,
// otherwise the bench confirms md_i is ignored and busy_o stays low.
module tb_ex_stage_mdu;
    localparam int XLEN = 32, CTRL_W = 8, RD_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ex_stage_mdu_if #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RD_W(RD_W)) bus ();

    ex_stage_mdu #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.valid_i = 0; bus.flush_i = 0; bus.stall_i = 0; bus.pc_i = '0; bus.imm_i = '0;
        bus.rd1_i = '0; bus.rd2_i = '0; bus.res_m_i = '0; bus.res_w_i = '0;
        bus.fwd_a_i = '0; bus.fwd_b_i = '0; bus.alu_src_i = 0; bus.alu_op_i = '0;
        bus.funct3_i = '0; bus.funct7_5_i = 0; bus.md_i = 0; bus.rd_i = '0; bus.ctrl_i = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_o), 0);
        chk({tag, "_alu"}, bus.alu_out_o, 0);
        chk({tag, "_pcimm"}, bus.pc_imm_o, 0);
        chk({tag, "_wdata"}, bus.wdata_o, 0);
        chk({tag, "_rd"}, 32'(bus.rd_o), 0);
        chk({tag, "_ctrl"}, 32'(bus.ctrl_o), 0);
        chk({tag, "_eq"}, 32'(bus.eq_o), 0);
        chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    endtask

    function automatic logic [31:0] sel_src(input logic [1:0] s, input logic [31:0] r, w, m);
        if (s == 2'b01) return w;
        if (s == 2'b10) return m;
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [2:0] f3,
                                            input logic f75, input logic [31:0] a, b);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = b[4:0];
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f3)
            3'd0: r = f75 ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: r = f75 ? $signed(a) >>> sh : a >> sh;
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, b);
        longint      sa, sb, ua;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ua = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ua; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    task automatic alu_rand(input bit md_rand);
        logic [31:0] a, bs, op2, exp;
        logic        v;
        v = ($urandom_range(0, 3) != 0);
        bus.valid_i = v;
        bus.md_i = md_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rd1_i = $urandom; bus.rd2_i = $urandom; bus.res_m_i = $urandom; bus.res_w_i = $urandom;
        bus.imm_i = $urandom; bus.pc_i = $urandom;
        bus.fwd_a_i = 2'($urandom_range(0, 3)); bus.fwd_b_i = 2'($urandom_range(0, 3));
        bus.alu_src_i = 1'($urandom_range(0, 1)); bus.alu_op_i = 2'($urandom_range(0, 3));
        bus.funct3_i = 3'($urandom_range(0, 7)); bus.funct7_5_i = 1'($urandom_range(0, 1));
        bus.rd_i = 5'($urandom); bus.ctrl_i = 8'($urandom);
        if (bus.funct3_i == 3'd0 && bus.alu_src_i) bus.funct7_5_i = 0;
        if ($urandom_range(0, 3) == 0) begin
            bus.rd2_i = bus.rd1_i; bus.fwd_b_i = 2'b00; bus.fwd_a_i = 2'b00; bus.alu_src_i = 0;
            if (bus.funct3_i == 3'd0) bus.funct7_5_i = 0;
        end
        a   = sel_src(bus.fwd_a_i, bus.rd1_i, bus.res_w_i, bus.res_m_i);
        bs  = sel_src(bus.fwd_b_i, bus.rd2_i, bus.res_w_i, bus.res_m_i);
        op2 = bus.alu_src_i ? bus.imm_i : bs;
        exp = ref_alu(bus.alu_op_i, bus.funct3_i, bus.funct7_5_i, a, op2);
        chk("alu_busy", 32'(bus.busy_o), 0);
        tick();
        chk("alu_valid", 32'(bus.valid_o), 32'(v));
        if (v) begin
            chk("alu_out", bus.alu_out_o, exp);
            chk("alu_pcimm", bus.pc_imm_o, bus.pc_i + bus.imm_i);
            chk("alu_wdata", bus.wdata_o, bs);
            chk("alu_eq", 32'(bus.eq_o), 32'(a == op2));
            chk("alu_rd", 32'(bus.rd_o), 32'(bus.rd_i));
            chk("alu_ctrl", 32'(bus.ctrl_o), 32'(bus.ctrl_i));
        end else begin
            chk("alu_bubble_ctrl", 32'(bus.ctrl_o), 0);
        end
    endtask

`ifdef EX_MDU_EN
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic md_op(input string tag, input logic [2:0] f3, input logic [31:0] a, b, input int stall_cyc);
        logic [31:0] exp;
        logic [4:0]  rd;
        logic [7:0]  ct;
        exp = ref_mdu(f3, a, b);
        rd = 5'($urandom); ct = 8'($urandom);
        clear_in();
        bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = f3; bus.rd1_i = a; bus.rd2_i = b;
        bus.rd_i = rd; bus.ctrl_i = ct;
        #1 chk({tag, "_busy_c0"}, 32'(bus.busy_o), 1);
        tick();
        bus.rd1_i = $urandom; bus.rd2_i = $urandom; bus.res_m_i = $urandom; bus.res_w_i = $urandom;
        bus.fwd_a_i = 2'b10; bus.fwd_b_i = 2'b01; bus.funct3_i = 3'($urandom_range(0, 7));
        bus.rd_i = 5'($urandom); bus.ctrl_i = 8'($urandom);
        for (int c = 1; c <= 32; c++) begin
            chk({tag, "_busy"}, 32'(bus.busy_o), 1);
            chk({tag, "_bubble"}, 32'(bus.valid_o), 0);
            tick();
        end
        if (stall_cyc > 0) begin
            bus.stall_i = 1;
            for (int s = 0; s < stall_cyc; s++) begin
                #1 chk({tag, "_stall_busy"}, 32'(bus.busy_o), 1);
                chk({tag, "_stall_hold"}, 32'(bus.valid_o), 0);
                tick();
            end
            bus.stall_i = 0;
        end
        #1 chk({tag, "_busy_done"}, 32'(bus.busy_o), 0);
        chk({tag, "_pre_valid"}, 32'(bus.valid_o), 0);
        tick();
        bus.valid_i = 0; bus.md_i = 0;
        chk({tag, "_valid"}, 32'(bus.valid_o), 1);
        chk({tag, "_res"}, bus.alu_out_o, exp);
        chk({tag, "_rd"}, 32'(bus.rd_o), 32'(rd));
        chk({tag, "_ctrl"}, 32'(bus.ctrl_o), 32'(ct));
        #1 chk({tag, "_busy_after"}, 32'(bus.busy_o), 0);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst = 1;
        tick(); tick();
        chk_zero("reset");
        rst = 0;

        // Directed ADD with immediate
        bus.valid_i = 1; bus.rd1_i = 5; bus.imm_i = 7; bus.alu_src_i = 1; bus.alu_op_i = 2'b00;
        bus.rd_i = 3; bus.ctrl_i = 8'hA5; bus.pc_i = 32'h100;
        #1 chk("add_busy", 32'(bus.busy_o), 0);
        tick();
        chk("add_out", bus.alu_out_o, 12);
        chk("add_valid", 32'(bus.valid_o), 1);
        chk("add_pcimm", bus.pc_imm_o, 32'h107);
        chk("add_rd", 32'(bus.rd_o), 3);
        chk("add_ctrl", 32'(bus.ctrl_o), 32'hA5);
        chk("add_busy2", 32'(bus.busy_o), 0);

        // Forwarded SUB and store data from writeback
        bus.fwd_a_i = 2'b10; bus.res_m_i = 32'h100; bus.rd1_i = 1; bus.alu_op_i = 2'b01;
        bus.imm_i = 32'h10; bus.fwd_b_i = 2'b01; bus.res_w_i = 32'hDEAD_BEEF; bus.rd2_i = 32'h55;
        tick();
        chk("fwd_sub", bus.alu_out_o, 32'hF0);
        chk("fwd_wdata", bus.wdata_o, 32'hDEAD_BEEF);
        chk("fwd_eq", 32'(bus.eq_o), 0);

        // Equality through forwarding
        bus.fwd_a_i = 2'b00; bus.rd1_i = 32'h1234; bus.alu_src_i = 0; bus.fwd_b_i = 2'b10;
        bus.res_m_i = 32'h1234; bus.alu_op_i = 2'b00;
        tick();
        chk("eq_out", bus.alu_out_o, 32'h2468);
        chk("eq_flag", 32'(bus.eq_o), 1);

        // Stall holds, flush beats stall
        bus.rd1_i = 1; bus.imm_i = 1; bus.alu_src_i = 1; bus.stall_i = 1;
        tick();
        chk("stall_out", bus.alu_out_o, 32'h2468);
        chk("stall_valid", 32'(bus.valid_o), 1);
        tick();
        chk("stall_eq", 32'(bus.eq_o), 1);
        bus.flush_i = 1;
        tick();
        chk("flush_valid", 32'(bus.valid_o), 0);
        chk("flush_out", bus.alu_out_o, 0);
        bus.flush_i = 0; bus.stall_i = 0;
        tick();
        chk("unstall_out", bus.alu_out_o, 2);

`ifdef EX_MDU_EN
        for (int i = 0; i < 150; i++) alu_rand(1'b0);
        md_op("mul", 3'd0, 32'hFFFF_FFFF, 32'd2, 0);
        md_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        md_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        md_op("divu_z", 3'd5, 32'h1234_5678, 32'd0, 0);
        md_op("rem_z", 3'd6, 32'd7, 32'd0, 0);
        md_op("div_negz", 3'd4, 32'hFFFF_FFF9, 32'd0, 0);
        md_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        md_op("stall_mulhsu", 3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 3);
        for (int i = 0; i < 16; i++)
            md_op("md_rand", 3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 3) == 0) ? 2 : 0);

        // Flush in the middle of BUSY
        clear_in();
        bus.valid_i = 1; bus.md_i = 1; bus.rd1_i = 32'd9; bus.rd2_i = 32'd9;
        tick();
        for (int c = 1; c < 10; c++) tick();
        bus.flush_i = 1; bus.valid_i = 0; bus.md_i = 0;
        tick();
        bus.flush_i = 0;
        chk("flush_md_busy", 32'(bus.busy_o), 0);
        for (int c = 11; c <= 36; c++) begin
            chk("flush_md_valid", 32'(bus.valid_o), 0);
            tick();
        end
        bus.valid_i = 1; bus.rd1_i = 40; bus.imm_i = 2; bus.alu_src_i = 1;
        tick();
        chk("flush_md_next", bus.alu_out_o, 42);
        chk("flush_md_nextv", 32'(bus.valid_o), 1);

        // Reset in the middle of an operation
        clear_in();
        bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = 3'd4; bus.rd1_i = 100; bus.rd2_i = 7;
        for (int c = 0; c < 5; c++) tick();
        rst = 1; bus.valid_i = 0; bus.md_i = 0;
        tick();
        chk_zero("rst_mid");
        rst = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("rst_mid_idle", 32'(bus.valid_o), 0);
        end
`else
        for (int i = 0; i < 200; i++) alu_rand(1'b1);
        clear_in();
        bus.valid_i = 1; bus.md_i = 1; bus.funct3_i = 3'd0; bus.rd1_i = 32'hFFFF_FFFF;
        bus.rd2_i = 32'd2; bus.alu_op_i = 2'b10;
        #1 chk("nomdu_busy", 32'(bus.busy_o), 0);
        tick();
        chk("nomdu_alu", bus.alu_out_o, 32'd1);
        chk("nomdu_valid", 32'(bus.valid_o), 1);
        bus.valid_i = 0; bus.md_i = 0; rst = 1;
        tick();
        chk_zero("rst_again");
        rst = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
